// File: rtl/conv_addr_gen.sv
// rtl/conv_addr_gen.sv - convolution address/strobe generator, one kernel tap per cycle
module conv_addr_gen #(
  parameter int ADDR_W  = 10,
  parameter int N_W     = 5,
  parameter int MAC_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_W-1:0]    cfg_n,
  input  logic [2:0]        cfg_k,
  input  logic [1:0]        cfg_s,
  input  logic              stall,
  output logic [ADDR_W-1:0] in_addr,
  output logic [5:0]        k_addr,
  output logic              addr_valid,
  output logic              acc_clr,
  output logic              acc_last,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_valid,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam int CW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;

  logic [N_W-1:0]    n_q, o_q;
  logic [2:0]        k_q;
  logic [1:0]        s_q;
  logic [2:0]        kc_q, kr_q;
  logic [N_W-1:0]    oc_q, or_q;
  logic              fin_q;
  logic [CW-1:0]     drn_q;
  logic [ADDR_W-1:0] pix_q;
  logic [MAC_LAT-1:0] dl_v;
  logic [ADDR_W-1:0] dl_a [MAC_LAT];

  logic              accept, cfg_ok, issue, tap_last;
  logic [N_W-1:0]    cfg_o, diff;
  logic [N_W-1:0]    en, eo, eoc, eor, noc, nor_;
  logic [2:0]        ek, ekc, ekr, nkc, nkr;
  logic [1:0]        es;
  logic [ADDR_W-1:0] row, col, in_addr_d, pix_d;
  logic [5:0]        k_addr_d;

  assign accept = (state_q == IDLE) && start;
  assign cfg_ok = (cfg_k != 3'd0) && (cfg_s != 2'd0) &&
                  ({{N_W{1'b0}}, cfg_k} <= {3'b000, cfg_n});

  always_comb begin
    diff = cfg_n - N_W'(cfg_k);
    case (cfg_s)
      2'd1:    cfg_o = diff;
      2'd2:    cfg_o = diff >> 1;
      default: cfg_o = diff / N_W'(3);
    endcase
    cfg_o = cfg_o + N_W'(1);
  end

  // At the accepting edge the first tap is issued straight from the incoming config.
  assign en  = accept ? cfg_n  : n_q;
  assign ek  = accept ? cfg_k  : k_q;
  assign es  = accept ? cfg_s  : s_q;
  assign eo  = accept ? cfg_o  : o_q;
  assign ekc = accept ? 3'd0 : kc_q;
  assign ekr = accept ? 3'd0 : kr_q;
  assign eoc = accept ? '0 : oc_q;
  assign eor = accept ? '0 : or_q;

  assign issue = !stall && ((accept && cfg_ok) || (state_q == RUN && !fin_q));
  assign tap_last = (ekc == ek - 3'd1) && (ekr == ek - 3'd1) &&
                    (eoc == eo - N_W'(1)) && (eor == eo - N_W'(1));

  always_comb begin
    nkc  = ekc + 3'd1;
    nkr  = ekr;
    noc  = eoc;
    nor_ = eor;
    if (ekc == ek - 3'd1) begin
      nkc = 3'd0;
      nkr = ekr + 3'd1;
      if (ekr == ek - 3'd1) begin
        nkr = 3'd0;
        noc = eoc + N_W'(1);
        if (eoc == eo - N_W'(1)) begin
          noc  = '0;
          nor_ = eor + N_W'(1);
        end
      end
    end
  end

  assign row       = ADDR_W'(eor) * ADDR_W'(es) + ADDR_W'(ekr);
  assign col       = ADDR_W'(eoc) * ADDR_W'(es) + ADDR_W'(ekc);
  assign in_addr_d = row * ADDR_W'(en) + col;
  assign k_addr_d  = 6'(ekr) * 6'(ek) + 6'(ekc);
  assign pix_d     = ADDR_W'(eor) * ADDR_W'(eo) + ADDR_W'(eoc);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = cfg_ok ? RUN : DONE;
      RUN:     if (fin_q) state_d = DRAIN;
      DRAIN:   if (drn_q == CW'(MAC_LAT - 1)) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      n_q        <= '0;
      o_q        <= '0;
      k_q        <= '0;
      s_q        <= '0;
      kc_q       <= '0;
      kr_q       <= '0;
      oc_q       <= '0;
      or_q       <= '0;
      fin_q      <= 1'b0;
      drn_q      <= '0;
      pix_q      <= '0;
      in_addr    <= '0;
      k_addr     <= '0;
      addr_valid <= 1'b0;
      acc_clr    <= 1'b0;
      acc_last   <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      state_q <= state_d;
      drn_q   <= (state_q == DRAIN) ? drn_q + CW'(1) : '0;
      if (accept) cfg_err <= !cfg_ok;
      if (accept && cfg_ok) begin
        n_q <= cfg_n;
        k_q <= cfg_k;
        s_q <= cfg_s;
        o_q <= cfg_o;
      end
      if (accept || issue) fin_q <= issue && tap_last;
      if (issue) begin
        kc_q <= nkc;
        kr_q <= nkr;
        oc_q <= noc;
        or_q <= nor_;
      end else if (accept) begin
        kc_q <= '0;
        kr_q <= '0;
        oc_q <= '0;
        or_q <= '0;
      end
      addr_valid <= issue;
      acc_clr    <= issue && (ekr == 3'd0) && (ekc == 3'd0);
      acc_last   <= issue && (ekr == ek - 3'd1) && (ekc == ek - 3'd1);
      if (issue) begin
        in_addr <= in_addr_d;
        k_addr  <= k_addr_d;
        pix_q   <= pix_d;
      end
    end
  end

  // Free-running delay line: models accumulator latency regardless of stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dl_v <= '0;
      for (int i = 0; i < MAC_LAT; i++) dl_a[i] <= '0;
    end else begin
      dl_v[0] <= acc_last && addr_valid;
      dl_a[0] <= pix_q;
      for (int i = 1; i < MAC_LAT; i++) begin
        dl_v[i] <= dl_v[i-1];
        dl_a[i] <= dl_a[i-1];
      end
    end
  end

  assign out_valid = dl_v[MAC_LAT-1];
  assign out_addr  = dl_a[MAC_LAT-1];
  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);

endmodule
